// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle load/store responder with lane select, extension and fault flagging
module data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_stall
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          a_we;
    logic [2:0]    a_f3;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          c_we;
    logic [2:0]    c_f3;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [AW-1:0] idx;
    logic          fault;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   rdata;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign req_ready  = (state == IDLE) && reset;
    assign mem_stall  = req_valid && (state != RESP);
    assign accept     = req_valid && req_ready;
    // With LATENCY==1 the RESP-entry edge is the accept edge itself, so the
    // request is decoded straight from the inputs while still in IDLE.
    assign enter_resp = (state == BUSY && cnt == 4'd1) || (accept && LATENCY == 1);
    assign c_we       = (state == IDLE) ? req_we     : a_we;
    assign c_f3       = (state == IDLE) ? req_funct3 : a_f3;
    assign c_addr     = (state == IDLE) ? req_addr   : a_addr;
    assign c_wdata    = (state == IDLE) ? req_wdata  : a_wdata;
    assign idx        = c_addr[AW+1:2];

    // Decode faults, select/extend load lanes and build store byte enables
    always_comb begin
        fault    = (c_we ? (c_f3 > 3'd2) : (c_f3 == 3'd3 || c_f3[2:1] == 2'b11))
                 || (c_f3[1:0] == 2'b01 && c_addr[0])
                 || (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00)
                 || (c_addr[31:2] >= 30'(DEPTH));
        word     = mem[idx];
        byte_sel = word[{c_addr[1:0], 3'b000} +: 8];
        half_sel = c_addr[1] ? word[31:16] : word[15:0];
        rdata    = (fault || c_we) ? 32'd0
                 : (c_f3[1:0] == 2'b00) ? {{24{~c_f3[2] & byte_sel[7]}}, byte_sel}
                 : (c_f3[1:0] == 2'b01) ? {{16{~c_f3[2] & half_sel[15]}}, half_sel}
                 : word;
        be       = (c_f3[1:0] == 2'b00) ? (4'b0001 << c_addr[1:0])
                 : (c_f3[1:0] == 2'b01) ? (c_addr[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;
        wd       = (c_f3[1:0] == 2'b00) ? {4{c_wdata[7:0]}}
                 : (c_f3[1:0] == 2'b01) ? {2{c_wdata[15:0]}}
                 : c_wdata;
    end

    // Sequence IDLE -> BUSY -> RESP, latching the request and registering the response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            if (enter_resp) begin
                resp_rdata <= rdata;
                resp_fault <= fault;
            end
            case (state)
                IDLE: if (accept) begin
                    a_we    <= req_we;
                    a_f3    <= req_funct3;
                    a_addr  <= req_addr;
                    a_wdata <= req_wdata;
                    cnt     <= 4'(LATENCY - 1);
                    state   <= (LATENCY == 1) ? RESP : BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit store bytes on the RESP-entry edge; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && enter_resp && c_we && !fault)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: table-driven scoreboard bench for data_mem_resp
module tb_data_mem_resp;
    localparam int LAT = 2;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_fault, mem_stall;
    logic [31:0] resp_rdata;

    logic        v1 = 1'b0, we1 = 1'b0;
    logic [2:0]  f31 = 3'd0;
    logic [31:0] a1 = 32'd0, wd1 = 32'd0;
    logic        ready1, rv1, fault1, stall1;
    logic [31:0] rdata1;

    int          n_vec = 0;
    int          n_bad = 0;
    string       tag = "reset";
    logic [32:0] sbq[$];
    vec_t        tbl[$];

    data_mem_resp #(.DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_stall(mem_stall)
    );

    data_mem_resp #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(ready1),
        .req_we(we1), .req_funct3(f31), .req_addr(a1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_rdata(rdata1), .resp_fault(fault1),
        .mem_stall(stall1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wdt,
                                logic [31:0] rd, logic flt);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wdt; v.rdata = rd; v.fault = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got 0x%08h, required 0x%08h", nm, tag, act, exp);
        end
    endtask

    task automatic sb_pop();
        logic [32:0] e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_unexpected [%s]: got a response, required none pending", tag);
        end else begin
            e = sbq.pop_front();
            chk("rdata", resp_rdata, e[31:0]);
            chk("fault", resp_fault, {31'd0, e[32]});
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        #1;
        chk("ready_at_accept", req_ready, 1);
        chk("stall_at_accept", mem_stall, 1);
    endtask

    task automatic run(input vec_t v);
        issue(v);
        sbq.push_back({v.fault, v.rdata});
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("resp_valid", resp_valid, {31'd0, k == LAT});
            chk("stall", mem_stall, {31'd0, k != LAT});
            if (resp_valid) sb_pop();
        end
        req_valid = 1'b0;
    endtask

    initial begin
        tbl.push_back(mk(1, 2, 'h10,  'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 2, 'h10,  0, 'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 'h13,  0, 'hFFFFFFDE, 0));
        tbl.push_back(mk(0, 4, 'h13,  0, 'h000000DE, 0));
        tbl.push_back(mk(0, 1, 'h10,  0, 'hFFFFBEEF, 0));
        tbl.push_back(mk(0, 5, 'h12,  0, 'h0000DEAD, 0));
        tbl.push_back(mk(1, 0, 'h11,  'h55, 0, 0));
        tbl.push_back(mk(0, 2, 'h10,  0, 'hDEAD55EF, 0));
        tbl.push_back(mk(1, 1, 'h12,  'h1234, 0, 0));
        tbl.push_back(mk(0, 2, 'h10,  0, 'h123455EF, 0));
        tbl.push_back(mk(0, 2, 'h11,  0, 0, 1));
        tbl.push_back(mk(1, 1, 'h13,  'hABCD, 0, 1));
        tbl.push_back(mk(0, 2, 'h10,  0, 'h123455EF, 0));
        tbl.push_back(mk(0, 3, 'h10,  0, 0, 1));
        tbl.push_back(mk(0, 6, 'h10,  0, 0, 1));
        tbl.push_back(mk(0, 7, 'h10,  0, 0, 1));
        tbl.push_back(mk(1, 3, 'h10,  'hFFFFFFFF, 0, 1));
        tbl.push_back(mk(1, 4, 'h10,  'hFFFFFFFF, 0, 1));
        tbl.push_back(mk(0, 2, 'h1000, 0, 0, 1));
        tbl.push_back(mk(1, 2, 'h1000, 1, 0, 1));
        tbl.push_back(mk(0, 1, 'h11,  0, 0, 1));
        tbl.push_back(mk(0, 5, 'h13,  0, 0, 1));
        tbl.push_back(mk(1, 2, 'h12,  0, 0, 1));
        tbl.push_back(mk(0, 2, 'h10,  0, 'h123455EF, 0));
        tbl.push_back(mk(0, 0, 'h11,  0, 'h00000055, 0));
        tbl.push_back(mk(0, 0, 'h10,  0, 'hFFFFFFEF, 0));
        tbl.push_back(mk(0, 1, 'h12,  0, 'h00001234, 0));
        tbl.push_back(mk(0, 5, 'h10,  0, 'h000055EF, 0));
        tbl.push_back(mk(1, 2, 'h14,  0, 0, 0));
        tbl.push_back(mk(1, 0, 'h16,  'hAAAAAA77, 0, 0));
        tbl.push_back(mk(0, 2, 'h14,  0, 'h00770000, 0));
        tbl.push_back(mk(1, 1, 'h14,  'hFFFF8001, 0, 0));
        tbl.push_back(mk(0, 1, 'h14,  0, 'hFFFF8001, 0));
        tbl.push_back(mk(0, 2, 'h14,  0, 'h00778001, 0));
        tbl.push_back(mk(1, 2, 'h20,  'hCAFEF00D, 0, 0));
        tbl.push_back(mk(0, 2, 'h20,  0, 'hCAFEF00D, 0));
        tbl.push_back(mk(1, 2, 'hFFC, 'h01020304, 0, 0));
        tbl.push_back(mk(0, 2, 'hFFC, 0, 'h01020304, 0));
        tbl.push_back(mk(0, 0, 'hFFF, 0, 'h00000001, 0));
        tbl.push_back(mk(0, 2, 'h80000000, 0, 0, 1));

        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_fault", resp_fault, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_resp_valid1", rv1, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);

        foreach (tbl[i]) begin
            tag = $sformatf("vec%0d addr=%08h f3=%0d we=%0b", i, tbl[i].addr, tbl[i].f3, tbl[i].we);
            run(tbl[i]);
        end

        tag = "hold_valid";
        issue(mk(0, 2, 'h10, 0, 0, 0));
        sbq.push_back({1'b0, 32'h123455EF});
        sbq.push_back({1'b0, 32'h123455EF});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_resp_valid_c%0d", k), resp_valid, {31'd0, k == 2 || k == 5});
            if (k == 2) chk("hold_ready_in_resp", req_ready, 0);
            if (k == 3) chk("hold_ready_next_idle", req_ready, 1);
            if (resp_valid) sb_pop();
        end
        req_valid = 1'b0;

        tag = "reset_in_busy";
        issue(mk(1, 2, 'h20, 'h11111111, 0, 0));
        @(negedge clk);
        chk("busy_resp_valid", resp_valid, 0);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rb_resp_valid", resp_valid, 0);
        chk("rb_rdata", resp_rdata, 0);
        chk("rb_fault", resp_fault, 0);
        chk("rb_ready", req_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rb_after_resp_valid", resp_valid, 0);
        run(mk(0, 2, 'h20, 0, 'hCAFEF00D, 0));

        tag = "reset_in_resp_load";
        issue(mk(0, 2, 'hFFC, 0, 0, 0));
        sbq.push_back({1'b0, 32'h01020304});
        @(negedge clk);
        @(negedge clk);
        chk("rr_resp_valid", resp_valid, 1);
        if (resp_valid) sb_pop();
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rr_dropped_valid", resp_valid, 0);
        chk("rr_rdata_cleared", resp_rdata, 0);
        reset = 1'b1;

        tag = "reset_in_resp_store";
        issue(mk(1, 2, 'h24, 'h00000077, 0, 0));
        @(negedge clk);
        @(negedge clk);
        chk("rs_resp_valid", resp_valid, 1);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rs_dropped_valid", resp_valid, 0);
        reset = 1'b1;
        run(mk(0, 2, 'h24, 0, 'h00000077, 0));

        tag = "lat1";
        @(negedge clk);
        v1 = 1'b1; we1 = 1'b1; f31 = 3'd2; a1 = 'h40; wd1 = 'h5A5A5A5A;
        #1;
        chk("l1_ready", ready1, 1);
        chk("l1_stall_accept", stall1, 1);
        @(negedge clk);
        chk("l1_sw_resp_valid", rv1, 1);
        chk("l1_sw_stall", stall1, 0);
        chk("l1_sw_rdata", rdata1, 0);
        chk("l1_sw_fault", fault1, 0);
        v1 = 1'b0;
        @(negedge clk);
        chk("l1_idle_resp_valid", rv1, 0);
        v1 = 1'b1; we1 = 1'b0; f31 = 3'd2; a1 = 'h40; wd1 = 0;
        #1;
        chk("l1_lw_ready", ready1, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("l1_hold_resp_valid_c%0d", k), rv1, {31'd0, k != 2});
            if (k == 2) chk("l1_hold_ready", ready1, 1);
            if (rv1) chk("l1_lw_rdata", rdata1, 'h5A5A5A5A);
        end
        v1 = 1'b0;
        @(negedge clk);
        chk("l1_quiet", rv1, 0);

        tag = "end";
        chk("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle data-memory responder that services load/store requests issued by the MEM stage of the 5-stage RISC-V pipeline. It produces the read data the pipeline later registers into MEM/WB. Requests are accepted one at a time over a valid/ready handshake. The block holds a word-organised storage array, performs byte/half/word lane selection and sign/zero extension, and flags illegal, misaligned or out-of-range accesses. While a transaction is outstanding, it drives a stall to the pipeline.

## Interface
- DEPTH, 1024: number of 32-bit words in the array; word index = addr[31:2].
- LATENCY, 2: cycles from the accept cycle to the response cycle; legal range 1..15.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present; held by the MEM stage until its response cycle.
- req_ready  out  1  responder can accept; high only in IDLE and never while reset is low.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present for exactly one cycle.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  request was illegal, misaligned or out of range.
- mem_stall  out  1  = req_valid && state != RESP (combinational).

## Operation
- States:
  - IDLE: accepts requests.
  - BUSY: counting latency.
  - RESP: response presented.
- Accept: req_valid && req_ready in IDLE. On that edge, latch we, funct3, addr and wdata, and load the counter with LATENCY-1.
- Transitions out of IDLE on accept: if LATENCY==1, go to RESP. Otherwise go to BUSY.
- BUSY: decrement the counter each cycle. When the counter is 1, the next edge enters RESP.
- RESP always returns to IDLE on the next edge. No acceptance occurs in RESP, so a held req_valid is not double-accepted.
- Decode, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Every other funct3 is illegal.
- Decode, stores: 000 SB, 001 SH, 010 SW. Every other funct3 is illegal.
- Fault conditions:
  - illegal funct3;
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0;
  - addr[31:2] >= DEPTH.
- On a fault: no array write; resp_rdata=0; resp_fault=1. Latency is unchanged.
- Load lane selection: byte lane = addr[1:0]; half = addr[1].
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store writes modify only the addressed bytes: SB one lane, SH two lanes, SW all four. Other bytes are preserved.
- Array write and read sampling occur on the edge entering RESP. resp_rdata and resp_fault are registered on that edge.
- A load accepted after a store's RESP observes the stored data.
- req_valid deasserting in BUSY (flush) does not cancel the transaction. The response and any store still complete.
- Array contents are not cleared by reset.

## Timing
- Accept in cycle t ⇒ resp_valid=1 in cycle t+LATENCY only.
- mem_stall is high in cycles t..t+LATENCY-1 and low in cycle t+LATENCY.
- Back-to-back: the next request can be accepted at the earliest in cycle t+LATENCY+1, giving a throughput of one access per LATENCY+1 cycles.
- Reset values, after the first edge with reset low: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_fault=0. req_ready=0 while reset is low.
- Reset asserted in BUSY: return to IDLE, and no array write for the pending store. Reset asserted in RESP: drop resp_valid on the next edge. A write already committed on the RESP entry edge persists.
- With req_valid low: IDLE is held, mem_stall=0, resp_valid=0.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10, LATENCY=2 -> each resp_valid exactly 2 cycles after accept; LW returns 0xDEADBEEF with fault=0; mem_stall high for 2 cycles per access.
- After the SW above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
- Faults:
  - LW 0x11 -> fault=1, rdata=0;
  - SH 0x13 -> fault=1, and a following LW 0x10 shows the word unchanged;
  - funct3=011 -> fault=1;
  - addr=DEPTH*4 -> fault=1.
- Hold req_valid through RESP -> exactly one response; then a new request accepted in the following IDLE cycle. Repeat with LATENCY=1 -> RESP in cycle t+1.
- Drive reset low during BUSY of an SW to 0x20 -> no resp_valid; a later LW 0x20 returns the prior contents. Outputs read 0 in the cycle after reset.
